// File: rtl/cp0_exception_ctrl_pkg.sv
// cp0_pkg: CP0 register numbers, ExcCodes, cp0Op encodings and FSM states
// shared by the CP0 exception controller and its timer.
package cp0_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    localparam logic [2:0] CP0OP_MFC0 = 3'b001;
    localparam logic [2:0] CP0OP_MTC0 = 3'b010;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FLUSH  = 2'd1;
    localparam logic [1:0] ST_VECTOR = 2'd2;

    // Status bits software may change: IM[15:8], EXL[1], IE[0]
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    function automatic logic [31:0] cause_pack(
        input logic [7:2] ip,
        input logic [4:0] code
    );
        return {16'h0, ip, 2'b00, 1'b0, code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_exception_ctrl_if.sv
// MEM-stage view of the instruction seen by CP0: validity, PC,
// exception/ERET flags and the MFC0/MTC0 request.
interface cp0_exception_ctrl_if;

    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_exc;
    logic [4:0]  mem_excCode;
    logic        mem_eret;
    logic [2:0]  mem_cp0Op;
    logic [4:0]  mem_cp0Addr;
    logic [31:0] mem_cp0Wdata;

    modport master (
        output mem_valid, mem_pc, mem_exc, mem_excCode,
        output mem_eret, mem_cp0Op, mem_cp0Addr, mem_cp0Wdata
    );

    modport slave (
        input mem_valid, mem_pc, mem_exc, mem_excCode,
        input mem_eret, mem_cp0Op, mem_cp0Addr, mem_cp0Wdata
    );

endinterface

// File: rtl/cp0_exception_ctrl_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer interrupt TI.
// Only instantiated when TIMER_IRQ_EN is defined.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count_i,
    input  logic        wr_compare_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        ti_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        ti_q, ti_d;

    always_comb begin
        count_d   = wr_count_i ? wdata_i : count_q + 32'd1;
        compare_d = wr_compare_i ? wdata_i : compare_q;
        // Writing Compare acknowledges the timer interrupt
        if (wr_compare_i)
            ti_d = 1'b0;
        else
            ti_d = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            ti_q      <= ti_d;
        end
    end

    assign count_o   = count_q;
    assign compare_o = compare_q;
    assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 Status/Cause/EPC plus the precise exception/interrupt/ERET sequencer
// (RUN -> FLUSH -> VECTOR). Define TIMER_IRQ_EN to add Count/Compare.
module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter logic [31:0] RESET_STATUS = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           ext_int,
    cp0_exception_ctrl_if.slave  mem,
    output logic [31:0]          cp0Rdata,
    output logic                 flush,
    output logic                 redirect,
    output logic [31:0]          redirectPc,
    output logic [31:0]          status,
    output logic [31:0]          cause,
    output logic [31:0]          epc
);

    logic [1:0]  state_q, state_d;
    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] target_q, target_d;
    logic [4:0]  code_q, code_d;
    logic [7:2]  ip_q, ip_d;
    logic        ti;

    logic run, int_pend;
    logic take_exc, take_int, take_eret, take, mtc0;

    assign run      = (state_q == ST_RUN);
    assign int_pend = status_q[0] & ~status_q[1] &
                      (|({ip_q, 2'b00} & status_q[15:8]));

    assign take_exc  = run & mem.mem_valid & mem.mem_exc;
    assign take_int  = run & mem.mem_valid & ~mem.mem_exc & int_pend;
    assign take_eret = run & mem.mem_valid & ~mem.mem_exc & ~int_pend &
                       mem.mem_eret;
    assign take      = take_exc | take_int | take_eret;
    assign mtc0      = run & mem.mem_valid & ~take &
                       (mem.mem_cp0Op == CP0OP_MTC0);

`ifdef TIMER_IRQ_EN
    logic [31:0] count, compare;

    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .wr_count_i   (mtc0 && (mem.mem_cp0Addr == CP0_COUNT)),
        .wr_compare_i (mtc0 && (mem.mem_cp0Addr == CP0_COMPARE)),
        .wdata_i      (mem.mem_cp0Wdata),
        .count_o      (count),
        .compare_o    (compare),
        .ti_o         (ti)
    );
`else
    assign ti = 1'b0;
`endif

    // IP tracks the lines even while a sequence is in flight
    assign ip_d = {ext_int[5] | ti, ext_int[4:0]};

    always_comb begin
        status_d = status_q;
        epc_d    = epc_q;
        target_d = target_q;
        code_d   = code_q;
        unique case (1'b1)
            take_exc: begin
                epc_d       = mem.mem_pc;
                code_d      = mem.mem_excCode;
                status_d[1] = 1'b1;
                target_d    = EXC_VECTOR;
            end
            take_int: begin
                epc_d       = mem.mem_pc;
                code_d      = EXC_INT;
                status_d[1] = 1'b1;
                target_d    = EXC_VECTOR;
            end
            take_eret: begin
                status_d[1] = 1'b0;
                target_d    = epc_q;
            end
            mtc0: begin
                if (mem.mem_cp0Addr == CP0_STATUS)
                    status_d = (status_q & ~STATUS_WMASK) |
                               (mem.mem_cp0Wdata & STATUS_WMASK);
                else if (mem.mem_cp0Addr == CP0_EPC)
                    epc_d = mem.mem_cp0Wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (take) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_VECTOR;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            status_q <= RESET_STATUS;
            epc_q    <= '0;
            target_q <= '0;
            code_q   <= '0;
            ip_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            epc_q    <= epc_d;
            target_q <= target_d;
            code_q   <= code_d;
            ip_q     <= ip_d;
        end
    end

    always_comb begin
        cp0Rdata = '0;
        unique case (mem.mem_cp0Addr)
            CP0_STATUS:  cp0Rdata = status_q;
            CP0_CAUSE:   cp0Rdata = cause_pack(ip_q, code_q);
            CP0_EPC:     cp0Rdata = epc_q;
`ifdef TIMER_IRQ_EN
            CP0_COUNT:   cp0Rdata = count;
            CP0_COMPARE: cp0Rdata = compare;
`endif
            default:     cp0Rdata = '0;
        endcase
    end

    assign flush      = (state_q == ST_FLUSH);
    assign redirect   = (state_q == ST_VECTOR);
    assign redirectPc = target_q;
    assign status     = status_q;
    assign cause      = cause_pack(ip_q, code_q);
    assign epc        = epc_q;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Self-checking bench for cp0_exception_ctrl; expected redirect targets
// are queued at the decision cycle and popped when redirect appears.
module tb_cp0_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  ext_int;
    logic [31:0] cp0Rdata, redirectPc, status, cause, epc;
    logic        flush, redirect;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    cp0_exception_ctrl_if mif ();

    cp0_exception_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .ext_int    (ext_int),
        .mem        (mif),
        .cp0Rdata   (cp0Rdata),
        .flush      (flush),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .status     (status),
        .cause      (cause),
        .epc        (epc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.mem_valid    = 1'b0;
        mif.mem_pc       = '0;
        mif.mem_exc      = 1'b0;
        mif.mem_excCode  = '0;
        mif.mem_eret     = 1'b0;
        mif.mem_cp0Op    = 3'b000;
        mif.mem_cp0Addr  = '0;
        mif.mem_cp0Wdata = '0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        idle();
        mif.mem_valid    = 1'b1;
        mif.mem_cp0Op    = 3'b010;
        mif.mem_cp0Addr  = a;
        mif.mem_cp0Wdata = d;
        step();
        idle();
    endtask

    task automatic wait_redirect(input string nm);
        logic [31:0] e;
        bit seen;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (redirect === 1'b1) seen = 1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_redirect: got none expected pulse in 8 cycles",
                     nm);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (redirectPc !== e) begin
                n_fail++;
                $display("FAIL %s_target: got %h expected %h",
                         nm, redirectPc, e);
            end
        end
        step();
        chk({nm, "_back_to_run"}, {31'b0, redirect | flush}, 32'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ext_int = '0;
        idle();
        step();
        step();
        chk("rst_status", status, 32'h0);
        chk("rst_cause", cause, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_redirect", {31'b0, redirect}, 32'd0);
        chk("rst_redirectPc", redirectPc, 32'h0);
        rst = 1'b0;
        step();
    endtask

    task automatic test_syscall();
        mif.mem_valid   = 1'b1;
        mif.mem_exc     = 1'b1;
        mif.mem_excCode = 5'd8;
        mif.mem_pc      = 32'h100;
        exp_q.push_back(32'h80);
        step();
        idle();
        chk("sys_flush", {31'b0, flush}, 32'd1);
        chk("sys_epc", epc, 32'h100);
        chk("sys_code", {27'b0, cause[6:2]}, 32'd8);
        chk("sys_exl", {31'b0, status[1]}, 32'd1);
        wait_redirect("sys");
    endtask

    task automatic test_eret();
        do_mtc0(5'd14, 32'h104);
        chk("eret_epc_wr", epc, 32'h104);
        mif.mem_valid   = 1'b1;
        mif.mem_cp0Op   = 3'b001;
        mif.mem_cp0Addr = 5'd14;
        #1;
        chk("mfc0_epc", cp0Rdata, 32'h104);
        idle();
        mif.mem_valid = 1'b1;
        mif.mem_eret  = 1'b1;
        mif.mem_pc    = 32'h180;
        exp_q.push_back(32'h104);
        step();
        idle();
        chk("eret_flush", {31'b0, flush}, 32'd1);
        chk("eret_exl", {31'b0, status[1]}, 32'd0);
        wait_redirect("eret");
    endtask

    task automatic test_interrupt();
        ext_int = 6'b000001;
        do_mtc0(5'd12, 32'h0000_0401);
        chk("int_status", status, 32'h0000_0401);
        chk("int_ip2", {31'b0, cause[10]}, 32'd1);
        mif.mem_valid = 1'b1;
        mif.mem_pc    = 32'h200;
        exp_q.push_back(32'h80);
        step();
        idle();
        chk("int_flush", {31'b0, flush}, 32'd1);
        chk("int_epc", epc, 32'h200);
        chk("int_code", {27'b0, cause[6:2]}, 32'd0);
        chk("int_status_exl", status, 32'h0000_0403);
        wait_redirect("int");
        mif.mem_valid = 1'b1;
        mif.mem_pc    = 32'h300;
        step();
        idle();
        chk("int_masked_flush", {31'b0, flush}, 32'd0);
        chk("int_masked_epc", epc, 32'h200);
        ext_int = '0;
    endtask

    task automatic test_drop();
        mif.mem_valid    = 1'b1;
        mif.mem_exc      = 1'b1;
        mif.mem_excCode  = 5'd10;
        mif.mem_pc       = 32'h400;
        mif.mem_cp0Op    = 3'b010;
        mif.mem_cp0Addr  = 5'd14;
        mif.mem_cp0Wdata = 32'h0000_DEAD;
        exp_q.push_back(32'h80);
        step();
        idle();
        chk("drop_epc", epc, 32'h400);
        wait_redirect("drop");
        chk("drop_epc_after", epc, 32'h400);
        mif.mem_exc = 1'b1;
        mif.mem_pc  = 32'h500;
        step();
        idle();
        chk("novalid_flush", {31'b0, flush}, 32'd0);
        chk("novalid_epc", epc, 32'h400);
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        mif.mem_valid   = 1'b1;
        mif.mem_exc     = 1'b1;
        mif.mem_excCode = 5'd12;
        mif.mem_eret    = 1'b1;
        mif.mem_pc      = 32'h600;
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h80);
        step();
        mif.mem_pc = 32'h700;
        chk("b2b_flush", {31'b0, flush}, 32'd1);
        chk("b2b_epc0", epc, 32'h600);
        step();
        chk("b2b_redirect", {31'b0, redirect}, 32'd1);
        e = exp_q.pop_front();
        chk("b2b_target0", redirectPc, e);
        chk("b2b_epc_hold", epc, 32'h600);
        step();
        chk("b2b_run", {31'b0, flush | redirect}, 32'd0);
        step();
        idle();
        chk("b2b_flush2", {31'b0, flush}, 32'd1);
        chk("b2b_epc1", epc, 32'h700);
        chk("b2b_code", {27'b0, cause[6:2]}, 32'd12);
        wait_redirect("b2b");
    endtask

    task automatic test_regs();
        do_mtc0(5'd13, 32'hFFFF_FFFF);
        chk("cause_ro", cause, 32'h0000_0030);
        do_mtc0(5'd12, 32'hFFFF_FFFF);
        chk("status_mask", status, 32'h0000_FF03);
        mif.mem_valid   = 1'b1;
        mif.mem_cp0Op   = 3'b001;
        mif.mem_cp0Addr = 5'd12;
        #1;
        chk("mfc0_status", cp0Rdata, 32'h0000_FF03);
        mif.mem_cp0Addr = 5'd5;
        #1;
        chk("mfc0_unknown", cp0Rdata, 32'h0);
        idle();
        do_mtc0(5'd12, 32'h0);
        chk("status_clear", status, 32'h0);
    endtask

    task automatic test_timer();
`ifdef TIMER_IRQ_EN
        bit seen;
        do_mtc0(5'd12, 32'h0000_8001);
        do_mtc0(5'd9, 32'h0);
        do_mtc0(5'd11, 32'h5);
        mif.mem_valid   = 1'b1;
        mif.mem_cp0Op   = 3'b001;
        mif.mem_cp0Addr = 5'd11;
        #1;
        chk("tmr_compare", cp0Rdata, 32'h5);
        idle();
        mif.mem_valid = 1'b1;
        mif.mem_pc    = 32'h800;
        exp_q.push_back(32'h80);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (flush === 1'b1) seen = 1;
        end
        idle();
        chk("tmr_taken", {31'b0, seen}, 32'd1);
        chk("tmr_epc", epc, 32'h800);
        chk("tmr_ip7", {31'b0, cause[15]}, 32'd1);
        chk("tmr_code", {27'b0, cause[6:2]}, 32'd0);
        wait_redirect("tmr");
        do_mtc0(5'd11, 32'h0);
        step();
        chk("tmr_ip7_clr", {31'b0, cause[15]}, 32'd0);
        do_mtc0(5'd12, 32'h0);
`else
        do_mtc0(5'd9, 32'h1234);
        mif.mem_valid   = 1'b1;
        mif.mem_cp0Op   = 3'b001;
        mif.mem_cp0Addr = 5'd9;
        #1;
        chk("notmr_count", cp0Rdata, 32'h0);
        mif.mem_cp0Addr = 5'd11;
        #1;
        chk("notmr_compare", cp0Rdata, 32'h0);
        idle();
`endif
    endtask

    task automatic test_mid_reset();
        int nred;
        mif.mem_valid   = 1'b1;
        mif.mem_exc     = 1'b1;
        mif.mem_excCode = 5'd8;
        mif.mem_pc      = 32'h900;
        step();
        idle();
        chk("midrst_flush", {31'b0, flush}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", {30'b0, redirect, flush}, 32'd0);
        chk("midrst_epc", epc, 32'h0);
        nred = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (redirect !== 1'b0) nred++;
        end
        chk("midrst_noredirect", nred, 32'd0);
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_eret();
        test_interrupt();
        test_drop();
        test_back_to_back();
        test_regs();
        test_timer();
        test_mid_reset();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
